hps_matrix_bridge: RTL
======================

// Module: hps_matrix_bridge
// PURPOSE
//   Parametrised HPS<->FPGA mailbox bridge that replaces the single-element-per-word matrix
//   controller. Uses a 4-phase req/ack handshake and packs PACK elements per word.
//   Loads NxN operand matrices (N runtime-selectable up to MAX_DIM), launches the matrix
//   coprocessor with a start pulse, and streams results back with done/overflow/error status.
// PARAMETERS
//   DATA_W      32         mailbox word width; top 8 bits are control/status
//   ELEM_W      8          signed element width
//   MAX_DIM     5          max matrix dimension; storage is MAX_DIM*MAX_DIM per matrix
//   SYNC_STAGES 2          synchroniser depth on incoming req bit (>=2)
//   TIMEOUT_CYC 1048576    watchdog limit (used only with BRIDGE_WATCHDOG_EN)
//   PACK = (DATA_W-8)/ELEM_W (derived, 3 at defaults); DW = clog2(MAX_DIM+1)
// PORTS
//   clk          in   1                      system clock
//   reset_n      in   1                      asynchronous, active-low reset
//   data_in      in   DATA_W                 HPS->FPGA: [31]req [30]start [29]abort, [PACK*ELEM_W-1:0] payload
//   data_out     out  DATA_W                 FPGA->HPS: [31]ack [30]busy [29]done [28]ovf [27]err [26:24]state, low lanes result
//   cop_op       out  3                      opcode to coprocessor
//   cop_dim      out  DW                     active dimension N
//   cop_scalar   out  ELEM_W                 scalar operand
//   cop_a        out  MAX_DIM*MAX_DIM*ELEM_W matrix A flat, element k at [k*ELEM_W +: ELEM_W]
//   cop_b        out  MAX_DIM*MAX_DIM*ELEM_W matrix B flat, same layout
//   cop_start    out  1                      one-cycle launch pulse
//   cop_done     in   1                      result valid (level or pulse)
//   cop_overflow in   1                      sampled with cop_done
//   cop_result   in   MAX_DIM*MAX_DIM*ELEM_W result flat, same layout
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, all stored matrices, flags and counters cleared.
//   Handshake: req passes SYNC_STAGES flops, then rising edge detected. On a req rise, word is
//     consumed and ack=1 the next cycle. ack stays 1 until synced req is low, then drops next cycle.
//     Only one word is consumed per req rise.
//   Command word (req rise in IDLE with start=1): [2:0] op, [5:3] N, [13:6] scalar.
//     A req rise in IDLE with start=0 is acked and ignored.
//     N==0 or N>MAX_DIM -> ERR, err=1.
//     Otherwise clear A/B/result and done/ovf/err -> LOAD.
//   LOAD: stream of 2*N*N elements, A then B, row-major. Lane 0 holds the first element.
//     Word count is ceil(2N*N/PACK); lanes past the last element are ignored.
//     Element (r,c) stored at r*MAX_DIM+c; unused cells stay 0.
//     After the last word -> START.
//   START: cop_start=1 for exactly 1 cycle -> WAIT.
//   WAIT: on cop_done, latch cop_result and ovf=cop_overflow -> SEND, done=1.
//     A req rise during WAIT is acked; its data is discarded.
//   SEND: each req rise returns the next PACK result elements in lanes, row-major over NxN.
//     Unused lanes are 0. Lanes are valid while ack=1.
//     After ceil(N*N/PACK) words -> IDLE. done/ovf stay set until the next command.
//   ERR: only abort or reset exits. req rises are still acked.
//   abort=1 sampled on any req rise: -> IDLE in any state.
//     Clears stored data and flags; the word is acked. abort beats start in the same word.
//   busy=1 in LOAD/START/WAIT/SEND. state codes: IDLE0 LOAD1 START2 WAIT3 SEND4 ERR5.
//   Element counter width is clog2(2*MAX_DIM*MAX_DIM+1); no wrap occurs below that.
//   reset_n low mid-transfer: immediate return to reset values; cop_start never glitches high.
// CONFIGURATION
//   BRIDGE_WATCHDOG_EN defined:
//     WAIT counts cycles. At TIMEOUT_CYC without cop_done -> ERR, err=1, and
//     data_out[7:0]=8'hE1 until abort. Counter clears on WAIT entry.
//   Undefined: no counter; WAIT holds indefinitely; the 8'hE1 code never appears.
// TESTING
//   Reset with req=1 held: ack=0, state=0 until req drops and rises again after reset_n release.
//   Cmd op=0 N=2 scalar=0; A=1..4, B=5..8 over 3 words; coprocessor model adds.
//     -> 1 cop_start pulse; cop_a k=0,1,5,6 = 1,2,3,4 and the rest 0.
//     -> SEND words {6,8,10},{12,0,0}; done=1, ovf=0.
//   Cmd N=5: 17 load words, then 9 send words; last word lanes 1,2 = 0; state returns to 0.
//   Cmd N=0 and N=6: err=1, state=5; next abort word -> state=0, err=0.
//   Abort on the 2nd load word: state=0; following cmd N=1 computes correctly from cleared storage.
//   (BRIDGE_WATCHDOG_EN, TIMEOUT_CYC=100) cop_done tied 0 -> err=1 at cycle 100 of WAIT,
//     data_out[7:0]=8'hE1.

Source files
------------

// File: rtl/hps_matrix_bridge.sv
// HPS<->FPGA mailbox bridge: 4-phase req/ack, PACK elements per word, NxN operand load and result readback.
// Optional cop_done watchdog enabled by defining BRIDGE_WATCHDOG_EN.
module hps_matrix_bridge #(
  parameter int DATA_W      = 32,
  parameter int ELEM_W      = 8,
  parameter int MAX_DIM     = 5,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1048576,
  localparam int PACK = (DATA_W - 8) / ELEM_W,
  localparam int DW   = $clog2(MAX_DIM + 1),
  localparam int MW   = MAX_DIM * MAX_DIM * ELEM_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [2:0]        cop_op,
  output logic [DW-1:0]     cop_dim,
  output logic [ELEM_W-1:0] cop_scalar,
  output logic [MW-1:0]     cop_a,
  output logic [MW-1:0]     cop_b,
  output logic              cop_start,
  input  logic              cop_done,
  input  logic              cop_overflow,
  input  logic [MW-1:0]     cop_result
);
  localparam int CELLS = MAX_DIM * MAX_DIM;
  localparam int CW    = $clog2(2 * CELLS + 1);
  localparam int AW    = $clog2(CELLS + 1);
  localparam int LW    = PACK * ELEM_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0, LOAD = 3'd1, START = 3'd2, WAIT = 3'd3, SEND = 3'd4, ERR = 3'd5
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_s, req_d, req_rise;
  logic                   ack, done, ovf, err, busy;
  logic [MW-1:0]          res;
  logic [LW-1:0]          lanes;
  logic [CW-1:0]          elem_cnt, nn, total, limit;
  logic                   walk_b, nxt_b;
  logic [DW-1:0]          walk_r, walk_c, nxt_r, nxt_c;
  logic [PACK-1:0]        lane_v, lane_b;
  logic [AW-1:0]          lane_addr [PACK];
  logic [2:0]             cmd_n;
  logic                   cmd_bad, abort, start, unused_hi;
  logic [DATA_W-9:0]      low_word;
`ifdef BRIDGE_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0] wd_cnt;
  logic           wd_flag;
`endif

  assign req_s     = req_sync[SYNC_STAGES-1];
  assign req_rise  = req_s & ~req_d;
  assign abort     = data_in[DATA_W-3];
  assign start     = data_in[DATA_W-2];
  assign cmd_n     = data_in[5:3];
  assign cmd_bad   = (cmd_n == 3'd0) || (32'(cmd_n) > MAX_DIM);
  assign unused_hi = ^data_in[DATA_W-4:LW];
  assign nn        = CW'(cop_dim) * CW'(cop_dim);
  assign total     = nn + nn;
  assign limit     = (state == SEND) ? nn : total;
  assign busy      = (state == LOAD) || (state == START) || (state == WAIT) || (state == SEND);

  // Sync flops reset high so a req already held through reset is not seen as a rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_sync <= '1;
      req_d    <= 1'b1;
      ack      <= 1'b0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], data_in[DATA_W-1]};
      req_d    <= req_s;
      if (req_rise)    ack <= 1'b1;
      else if (!req_s) ack <= 1'b0;
    end
  end

  // Row-major walk over the NxN cells for each lane of the current word, A then B.
  always_comb begin
    nxt_b  = walk_b;
    nxt_r  = walk_r;
    nxt_c  = walk_c;
    lane_v = '0;
    lane_b = '0;
    for (int l = 0; l < PACK; l++) begin
      lane_addr[l] = AW'(nxt_r) * AW'(MAX_DIM) + AW'(nxt_c);
      lane_b[l]    = nxt_b;
      lane_v[l]    = (elem_cnt + CW'(l)) < limit;
      nxt_c        = nxt_c + DW'(1);
      if (nxt_c == cop_dim) begin
        nxt_c = '0;
        nxt_r = nxt_r + DW'(1);
        if (nxt_r == cop_dim) begin
          nxt_r = '0;
          nxt_b = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      done       <= 1'b0;
      ovf        <= 1'b0;
      err        <= 1'b0;
      cop_op     <= '0;
      cop_dim    <= '0;
      cop_scalar <= '0;
      cop_a      <= '0;
      cop_b      <= '0;
      cop_start  <= 1'b0;
      res        <= '0;
      lanes      <= '0;
      elem_cnt   <= '0;
      walk_b     <= 1'b0;
      walk_r     <= '0;
      walk_c     <= '0;
`ifdef BRIDGE_WATCHDOG_EN
      wd_cnt     <= '0;
      wd_flag    <= 1'b0;
`endif
    end else begin
      cop_start <= 1'b0;
      if (req_rise && abort) begin
        state      <= IDLE;
        done       <= 1'b0;
        ovf        <= 1'b0;
        err        <= 1'b0;
        cop_op     <= '0;
        cop_dim    <= '0;
        cop_scalar <= '0;
        cop_a      <= '0;
        cop_b      <= '0;
        res        <= '0;
        lanes      <= '0;
        elem_cnt   <= '0;
        walk_b     <= 1'b0;
        walk_r     <= '0;
        walk_c     <= '0;
`ifdef BRIDGE_WATCHDOG_EN
        wd_flag    <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: if (req_rise && start) begin
            done  <= 1'b0;
            ovf   <= 1'b0;
            lanes <= '0;
            if (cmd_bad) begin
              err   <= 1'b1;
              state <= ERR;
            end else begin
              err        <= 1'b0;
              cop_op     <= data_in[2:0];
              cop_dim    <= DW'(cmd_n);
              cop_scalar <= data_in[6 +: ELEM_W];
              cop_a      <= '0;
              cop_b      <= '0;
              res        <= '0;
              elem_cnt   <= '0;
              walk_b     <= 1'b0;
              walk_r     <= '0;
              walk_c     <= '0;
              state      <= LOAD;
            end
          end
          LOAD: if (req_rise) begin
            for (int l = 0; l < PACK; l++) begin
              if (lane_v[l]) begin
                if (lane_b[l]) cop_b[lane_addr[l]*ELEM_W +: ELEM_W] <= data_in[l*ELEM_W +: ELEM_W];
                else           cop_a[lane_addr[l]*ELEM_W +: ELEM_W] <= data_in[l*ELEM_W +: ELEM_W];
              end
            end
            if (elem_cnt + CW'(PACK) >= total) begin
              state     <= START;
              cop_start <= 1'b1;
            end else begin
              elem_cnt <= elem_cnt + CW'(PACK);
              walk_b   <= nxt_b;
              walk_r   <= nxt_r;
              walk_c   <= nxt_c;
            end
          end
          START: begin
            state <= WAIT;
`ifdef BRIDGE_WATCHDOG_EN
            wd_cnt <= '0;
`endif
          end
          WAIT: if (cop_done) begin
            res      <= cop_result;
            ovf      <= cop_overflow;
            done     <= 1'b1;
            elem_cnt <= '0;
            walk_b   <= 1'b0;
            walk_r   <= '0;
            walk_c   <= '0;
            state    <= SEND;
`ifdef BRIDGE_WATCHDOG_EN
          end else if (wd_cnt == WDW'(TIMEOUT_CYC - 1)) begin
            err     <= 1'b1;
            wd_flag <= 1'b1;
            state   <= ERR;
          end else begin
            wd_cnt <= wd_cnt + WDW'(1);
`endif
          end
          SEND: if (req_rise) begin
            for (int l = 0; l < PACK; l++)
              lanes[l*ELEM_W +: ELEM_W] <= lane_v[l] ? res[lane_addr[l]*ELEM_W +: ELEM_W] : '0;
            if (elem_cnt + CW'(PACK) >= nn) begin
              state <= IDLE;
            end else begin
              elem_cnt <= elem_cnt + CW'(PACK);
              walk_r   <= nxt_r;
              walk_c   <= nxt_c;
            end
          end
          ERR: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef BRIDGE_WATCHDOG_EN
  assign low_word = wd_flag ? {(DATA_W-8)'(lanes) >> 8, 8'hE1} : (DATA_W-8)'(lanes);
`else
  assign low_word = (DATA_W-8)'(lanes);
`endif

  assign data_out = {ack, busy, done, ovf, err, state, low_word};
endmodule
